// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receiver with receive FIFO.
// Parity modes, receiver FSM states and a width helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Pop and peek bus between the receive FIFO and its consumer.
// master = FIFO side, slave = consumer side.
interface uart_rx_fifo_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] peek_addr;
    logic [DW-1:0] peek_data;

    modport master (
        output rd_valid, rd_data, peek_data,
        input  rd_ready, peek_addr
    );

    modport slave (
        input  rd_valid, rd_data, peek_data,
        output rd_ready, peek_addr
    );
endinterface

// File: rtl/uart_rx_fifo_core.sv
// UART frame receiver: rx synchroniser, framing FSM, parity/stop checks.
// Emits a one-cycle push strobe with data, or one-cycle error pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 rx_i,
    output logic                 push_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o
);

    localparam int CW = clog2(CLKS_PER_BIT);
    localparam int IW = clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DATA_BITS - 1);
    localparam logic          PAR_INV  = (PARITY == PAR_ODD);

    logic                 rx_meta_q;
    logic                 rx_s_q;
    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_ok_q;
    logic                 push_q;
    logic                 ferr_q;
    logic                 perr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        push_q <= 1'b0;
        ferr_q <= 1'b0;
        perr_q <= 1'b0;
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            par_ok_q <= 1'b1;
        end else if (!en_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        par_ok_q <= 1'b1;
                        state_q  <= rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        shreg_q <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_MAX) begin
                            state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q    <= '0;
                        par_ok_q <= (rx_s_q == ((^shreg_q) ^ PAR_INV));
                        state_q  <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q  <= '0;
                        push_q <= rx_s_q && par_ok_q;
                        ferr_q <= !rx_s_q;
                        perr_q <= !par_ok_q;
                        // A low stop bit may be a break; hold off until the line idles.
                        state_q <= rx_s_q ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s_q) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign push_o       = push_q;
    assign data_o       = shreg_q;
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with first-word-fall-through receive FIFO, peek port,
// occupancy count and sticky overflow/frame/parity error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int DEPTH        = 8,
    localparam int AW          = clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            rx_i,
    input  logic            clr_err_i,
    uart_rx_fifo_if.master  rd_if,
    output logic [AW:0]     count_o,
    output logic            full_o,
    output logic            overflow_o,
    output logic            frame_err_o,
    output logic            parity_err_o
);

    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic                 push;
    logic [DATA_BITS-1:0] push_data;
    logic                 ferr_p;
    logic                 perr_p;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY       (PARITY)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .rx_i         (rx_i),
        .push_o       (push),
        .data_o       (push_data),
        .frame_err_o  (ferr_p),
        .parity_err_o (perr_p)
    );

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 full;
    logic                 do_pop;
    logic                 do_push;
    logic                 ovf_set;
    logic [AW-1:0]        peek_idx;

    assign full     = (count_q == CNT_FULL);
    assign do_pop   = rd_if.rd_valid && rd_if.rd_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign do_push  = push && (!full || do_pop);
    assign ovf_set  = push && full && !do_pop;
    assign peek_idx = rd_ptr_q + rd_if.peek_addr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d  = ovf_set | (ovf_q  & ~clr_err_i);
        ferr_d = ferr_p  | (ferr_q & ~clr_err_i);
        perr_d = perr_p  | (perr_q & ~clr_err_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign rd_if.rd_valid  = (count_q != '0);
    assign rd_if.rd_data   = mem_q[rd_ptr_q];
    assign rd_if.peek_data = mem_q[peek_idx];
    assign count_o         = count_q;
    assign full_o          = full;
    assign overflow_o      = ovf_q;
    assign frame_err_o     = ferr_q;
    assign parity_err_o    = perr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based model of the 8N1 receiver checked
// every cycle, plus literal checks and an 8E1 instance for parity.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int DB    = 8;
    // Drive of start bit to FIFO write: 2 sync + 1 detect + half bit + data + stop.
    localparam int LAT0  = 4 + CPB / 2 + CPB * (DB + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic clr0 = 1'b0;
    logic clr1 = 1'b0;
    logic [3:0] cnt0, cnt1;
    logic full0, ovf0, ferr0, perr0;
    logic full1, ovf1, ferr1, perr1;

    uart_rx_fifo_if #(.DW(8), .AW(3)) bus0 ();
    uart_rx_fifo_if #(.DW(8), .AW(3)) bus1 ();

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (DB),
        .PARITY (PAR_NONE), .DEPTH (DEPTH)
    ) u_dut (
        .clk (clk), .rst (rst), .en_i (en), .rx_i (rx0),
        .clr_err_i (clr0), .rd_if (bus0), .count_o (cnt0),
        .full_o (full0), .overflow_o (ovf0),
        .frame_err_o (ferr0), .parity_err_o (perr0)
    );

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (DB),
        .PARITY (PAR_EVEN), .DEPTH (DEPTH)
    ) u_par (
        .clk (clk), .rst (rst), .en_i (en), .rx_i (rx1),
        .clr_err_i (clr1), .rd_if (bus1), .count_o (cnt1),
        .full_o (full1), .overflow_o (ovf1),
        .frame_err_o (ferr1), .parity_err_o (perr1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    bit rdone  = 1'b0;

    typedef struct {
        int         at;
        bit         is_err;
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mq[$];
    bit m_ovf  = 1'b0;
    bit m_ferr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin : model
        ev_t        ev;
        bit         pop, pu, s_ovf, s_fe;
        logic [7:0] pd;
        cyc++;
        pop   = bus0.rd_ready && (mq.size() > 0);
        pu    = 1'b0;
        s_ovf = 1'b0;
        s_fe  = 1'b0;
        pd    = '0;
        if (evq.size() > 0 && evq[0].at == cyc) begin
            ev = evq.pop_front();
            if (ev.is_err) s_fe = 1'b1;
            else begin
                pu = 1'b1;
                pd = ev.d;
            end
        end
        if (rst) begin
            mq.delete();
            evq.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (pu) begin
                if (mq.size() < DEPTH) mq.push_back(pd);
                else s_ovf = 1'b1;
            end
            m_ovf  = s_ovf | (m_ovf  & !clr0);
            m_ferr = s_fe  | (m_ferr & !clr0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", bus0.rd_valid, mq.size() > 0);
            if (mq.size() > 0) chk("rd_data", bus0.rd_data, mq[0]);
            chk("count", cnt0, mq.size());
            chk("full", full0, mq.size() == DEPTH);
            chk("overflow", ovf0, m_ovf);
            chk("frame_err", ferr0, m_ferr);
            chk("parity_err", perr0, 0);
            if (int'(bus0.peek_addr) < mq.size())
                chk("peek_data", bus0.peek_data, mq[bus0.peek_addr]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic b, input int n);
        rx0 = b;
        repeat (n) tick();
    endtask

    task automatic drive1(input logic b, input int n);
        rx1 = b;
        repeat (n) tick();
    endtask

    // stop_low > 0 holds the stop bit low for that many cycles.
    task automatic send0(input logic [7:0] d, input int stop_low,
                         input int gap, input bit sched);
        ev_t e;
        e.at = cyc + LAT0;
        e.is_err = (stop_low > 0);
        e.d = d;
        if (sched) evq.push_back(e);
        drive0(1'b0, CPB);
        for (int i = 0; i < DB; i++) drive0(d[i], CPB);
        if (stop_low > 0) drive0(1'b0, stop_low);
        else drive0(1'b1, CPB);
        drive0(1'b1, gap);
    endtask

    task automatic send1(input logic [7:0] d, input logic p);
        drive1(1'b0, CPB);
        for (int i = 0; i < DB; i++) drive1(d[i], CPB);
        drive1(p, CPB);
        drive1(1'b1, CPB + 4);
    endtask

    task automatic pop0();
        bus0.rd_ready = 1'b1;
        tick();
        bus0.rd_ready = 1'b0;
    endtask

    initial begin
        bus0.rd_ready  = 1'b0;
        bus0.peek_addr = '0;
        bus1.rd_ready  = 1'b0;
        bus1.peek_addr = '0;
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        bus0.peek_addr = 3'd3;
        tick();
        chk("rst_count", cnt0, 0);
        chk("rst_valid", bus0.rd_valid, 0);
        chk("rst_peek", bus0.peek_data, 8'h00);
        chk("rst_full", full0, 0);
        bus0.peek_addr = '0;

        // Test 1: single byte, push timing, pop
        fork
            send0(8'hA5, 0, 4, 1'b1);
            begin
                repeat (LAT0 - 1) tick();
                chk("t1_not_yet", bus0.rd_valid, 0);
                tick();
                chk("t1_valid", bus0.rd_valid, 1);
                chk("t1_data", bus0.rd_data, 8'hA5);
                chk("t1_count", cnt0, 1);
            end
        join
        pop0();
        chk("t1_count_pop", cnt0, 0);
        chk("t1_valid_pop", bus0.rd_valid, 0);

        // Test 2: fill, overflow, ordered drain
        for (int i = 0; i < 8; i++) send0(8'(i), 0, 2, 1'b1);
        chk("t2_full", full0, 1);
        send0(8'h08, 0, 2, 1'b1);
        chk("t2_overflow", ovf0, 1);
        chk("t2_count", cnt0, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_order", bus0.rd_data, 8'(i));
            pop0();
        end

        // Test 3: framing error, recovery, clear
        send0(8'h3C, 2 * CPB, 4, 1'b1);
        chk("t3_ferr", ferr0, 1);
        chk("t3_nopush", cnt0, 0);
        send0(8'h11, 0, 2, 1'b1);
        chk("t3_count", cnt0, 1);
        chk("t3_data", bus0.rd_data, 8'h11);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        chk("t3_clr", ferr0, 0);
        pop0();

        // Test 4: even parity instance
        send1(8'h07, 1'b0);
        chk("t4_perr", perr1, 1);
        chk("t4_nopush", cnt1, 0);
        send1(8'h07, 1'b1);
        chk("t4_count", cnt1, 1);
        chk("t4_data", bus1.rd_data, 8'h07);

        // Receiver disabled: frame ignored
        en = 1'b0;
        send0(8'h5A, 0, 2, 1'b0);
        en = 1'b1;
        chk("en_off", cnt0, 0);

        // Test 5: glitch, then reset mid-frame
        drive0(1'b0, 4);
        drive0(1'b1, 20);
        chk("t5_glitch_cnt", cnt0, 0);
        chk("t5_glitch_fe", ferr0, 0);
        send0(8'h55, 0, 2, 1'b1);
        send0(8'h66, CPB, 4, 1'b1);
        chk("t5_pre_ferr", ferr0, 1);
        drive0(1'b0, 40);
        rst = 1'b1;
        rx0 = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_count", cnt0, 0);
        chk("t5_rst_ferr", ferr0, 0);
        chk("t5_rst_valid", bus0.rd_valid, 0);
        repeat (4) tick();

        // Test 6: peek, then push+pop while full
        send0(8'h10, 0, 0, 1'b1);
        send0(8'h20, 0, 0, 1'b1);
        send0(8'h30, 0, 2, 1'b1);
        pop0();
        bus0.peek_addr = 3'd1;
        #1;
        chk("t6_peek", bus0.peek_data, 8'h30);
        chk("t6_head", bus0.rd_data, 8'h20);
        for (int i = 4; i < 10; i++) send0(8'(i * 16), 0, 2, 1'b1);
        chk("t6_full", full0, 1);
        fork
            send0(8'hA0, 0, 4, 1'b1);
            begin
                repeat (LAT0 - 1) tick();
                bus0.rd_ready = 1'b1;
                tick();
                bus0.rd_ready = 1'b0;
                chk("t6_count8", cnt0, 8);
                chk("t6_no_ovf", ovf0, 0);
            end
        join
        bus0.peek_addr = 3'd7;
        #1;
        chk("t6_peek_tail", bus0.peek_data, 8'hA0);
        bus0.rd_ready = 1'b1;
        repeat (10) tick();
        bus0.rd_ready = 1'b0;

        // Randomised traffic against the model
        fork
            while (!rdone) begin
                bus0.rd_ready  = ($urandom % 3) == 0;
                bus0.peek_addr = 3'($urandom);
                clr0           = ($urandom % 40) == 0;
                tick();
            end
        join_none
        for (int n = 0; n < 25; n++) begin
            bit bs;
            bs = ($urandom % 5) == 0;
            if (bs) send0(8'($urandom), CPB * $urandom_range(1, 2),
                          $urandom_range(2, 10), 1'b1);
            else    send0(8'($urandom), 0, $urandom_range(0, 10), 1'b1);
        end
        rdone = 1'b1;
        repeat (2) tick();
        clr0 = 1'b0;
        bus0.rd_ready = 1'b1;
        repeat (20) tick();
        bus0.rd_ready = 1'b0;
        chk("end_empty", cnt0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
